// File: rtl/coeff_loader.sv
// rtl/coeff_loader.sv - walks a 4x16-bit coefficient bank into fir_filter over the load_coeff/modwait handshake
// Moore FSM; every output is a flop updated alongside the state register.

module coeff_loader #(
  parameter int NUM_COEFF = 4,
  parameter int TIMEOUT   = 10
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        new_coefficient_set,
  input  logic [63:0] coeff_bank,
  input  logic        modwait,
  output logic [15:0] fir_coefficient,
  output logic        load_coeff,
  output logic [1:0]  coefficient_num,
  output logic        clear_new_coeff,
  output logic        busy,
  output logic        load_err
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0]    LAST_IDX = 2'(NUM_COEFF - 1);

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    WAIT_LO,
    NEXT,
    DONE,
    ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;

  function automatic logic [15:0] pick(input logic [63:0] bank, input logic [1:0] i);
    return bank[{i, 4'b0000} +: 16];
  endfunction

  // coefficient_num doubles as the sequence index; the bank is only sampled when it advances.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state           <= IDLE;
      tmo_cnt         <= '0;
      fir_coefficient <= 16'h0000;
      load_coeff      <= 1'b0;
      coefficient_num <= 2'd0;
      clear_new_coeff <= 1'b0;
      busy            <= 1'b0;
      load_err        <= 1'b0;
    end else begin
      clear_new_coeff <= 1'b0;
      case (state)
        IDLE: begin
          if (new_coefficient_set) begin
            state           <= ASSERT;
            tmo_cnt         <= '0;
            coefficient_num <= 2'd0;
            fir_coefficient <= pick(coeff_bank, 2'd0);
            load_coeff      <= 1'b1;
            busy            <= 1'b1;
          end
        end

        // A modwait that is already high on entry is taken as the acknowledge.
        ASSERT: begin
          if (modwait) begin
            state      <= WAIT_LO;
            tmo_cnt    <= '0;
            load_coeff <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= ERR;
            tmo_cnt    <= '0;
            load_coeff <= 1'b0;
            load_err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end

        WAIT_LO: begin
          if (!modwait) begin
            state   <= NEXT;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= ERR;
            tmo_cnt  <= '0;
            load_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end

        NEXT: begin
          tmo_cnt <= '0;
          if (coefficient_num == LAST_IDX) begin
            state           <= DONE;
            clear_new_coeff <= 1'b1;
          end else begin
            state           <= ASSERT;
            coefficient_num <= coefficient_num + 2'd1;
            fir_coefficient <= pick(coeff_bank, coefficient_num + 2'd1);
            load_coeff      <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          tmo_cnt    <= '0;
          load_coeff <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// tb/tb_coeff_loader.sv - self-checking bench for coeff_loader
// Expected traces come from a cycle-timeline model built from filter delay/hold arithmetic.

module tb_coeff_loader;

  localparam int TIMEOUT = 10;
  localparam int MAXC    = 60;
  localparam int NV      = 14;

  logic        tb_clk = 1'b0;
  logic        n_reset;
  logic        new_coefficient_set;
  logic [63:0] coeff_bank;
  logic        modwait;
  logic [15:0] fir_coefficient;
  logic        load_coeff;
  logic [1:0]  coefficient_num;
  logic        clear_new_coeff;
  logic        busy;
  logic        load_err;

  always #5 tb_clk = ~tb_clk;

  coeff_loader #(.NUM_COEFF(4), .TIMEOUT(TIMEOUT)) dut (
    .clk                 (tb_clk),
    .n_reset             (n_reset),
    .new_coefficient_set (new_coefficient_set),
    .coeff_bank          (coeff_bank),
    .modwait             (modwait),
    .fir_coefficient     (fir_coefficient),
    .load_coeff          (load_coeff),
    .coefficient_num     (coefficient_num),
    .clear_new_coeff     (clear_new_coeff),
    .busy                (busy),
    .load_err            (load_err)
  );

  typedef struct {
    logic [63:0] bank;
    int          d;          // cycles from seeing load_coeff to raising modwait
    int          h;          // cycles modwait stays high
    int          drop;       // request is high for cycles [0, drop)
    bit          rnd;        // bank changes randomly every cycle
    int          exp_clears;
    bit          exp_err;
  } vec_t;

  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  int cur_d, cur_h, cur_drop, fstart;
  bit cur_rnd;

  logic [63:0] bank_hist[MAXC];
  bit          e_lc[MAXC], e_busy[MAXC], e_clr[MAXC], e_err[MAXC];
  int          e_k[MAXC], e_a[MAXC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit req_at(input int c);
    return c < cur_drop;
  endfunction

  task automatic mark(input int from, input int to, input bit lc, input int k, input int a);
    for (int i = from; i <= to; i++) begin
      if (i >= 0 && i < MAXC) begin
        e_busy[i] = 1'b1;
        if (lc) begin
          e_lc[i] = 1'b1;
          e_k[i]  = k;
          e_a[i]  = a;
        end
      end
    end
  endtask

  // Coefficient k is offered from cycle a for d+1 cycles, waits h cycles for modwait low,
  // spends one cycle in NEXT, so the following coefficient starts at a+d+h+2.
  task automatic build();
    int c, a, e;
    bit abort;
    for (int i = 0; i < MAXC; i++) begin
      e_lc[i] = 0; e_busy[i] = 0; e_clr[i] = 0; e_err[i] = 0; e_k[i] = -1; e_a[i] = 0;
    end
    c = 0;
    while (c < MAXC) begin
      if (!req_at(c)) begin
        c++;
      end else begin
        a = c + 1;
        e = 0;
        abort = 0;
        for (int k = 0; k < 4 && !abort; k++) begin
          if (cur_d >= TIMEOUT) begin
            mark(a, a + TIMEOUT - 1, 1, k, a);
            e = a + TIMEOUT;
            abort = 1;
          end else begin
            mark(a, a + cur_d, 1, k, a);
            if (cur_h > TIMEOUT) begin
              mark(a + cur_d + 1, a + cur_d + TIMEOUT, 0, 0, 0);
              e = a + cur_d + 1 + TIMEOUT;
              abort = 1;
            end else begin
              mark(a + cur_d + 1, a + cur_d + cur_h + 1, 0, 0, 0);
              a = a + cur_d + cur_h + 2;
            end
          end
        end
        if (abort) begin
          mark(e, e, 0, 0, 0);
          for (int i = e; i < MAXC; i++) e_err[i] = 1;
          c = e + 1;
        end else begin
          mark(a, a, 0, 0, 0);
          if (a < MAXC) e_clr[a] = 1;
          c = a + 1;
        end
      end
    end
  endtask

  // Behavioural filter: reacts to load_coeff, then drives inputs for the coming edge.
  task automatic drive(input int c);
    if (fstart >= 0 && c - fstart >= cur_d + cur_h) fstart = -1;
    if (fstart < 0 && load_coeff) fstart = c;
    modwait = (fstart >= 0 && c - fstart >= cur_d && c - fstart < cur_d + cur_h);
    new_coefficient_set = req_at(c);
    if (cur_rnd && $urandom_range(1, 0) == 1) coeff_bank = {$urandom, $urandom};
    if (c < MAXC) bank_hist[c] = coeff_bank;
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    new_coefficient_set = 1'b0;
    modwait = 1'b0;
    fstart = -1;
    repeat (2) @(posedge tb_clk);
    #1;
    n_reset = 1'b1;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int clears;
    logic [63:0] b;
    v = vecs[vi];
    cur_d = v.d; cur_h = v.h; cur_drop = v.drop; cur_rnd = v.rnd;
    coeff_bank = v.bank;
    build();
    apply_reset();
    clears = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (c > 0) begin
        @(posedge tb_clk);
        #1;
      end
      if (c == 0) begin
        chk($sformatf("v%0d reset fir_coefficient", vi), fir_coefficient, 16'h0000);
        chk($sformatf("v%0d reset coefficient_num", vi), coefficient_num, 2'd0);
      end
      chk($sformatf("v%0d c%0d load_coeff", vi, c), load_coeff, e_lc[c]);
      chk($sformatf("v%0d c%0d busy", vi, c), busy, e_busy[c]);
      chk($sformatf("v%0d c%0d clear_new_coeff", vi, c), clear_new_coeff, e_clr[c]);
      chk($sformatf("v%0d c%0d load_err", vi, c), load_err, e_err[c]);
      if (e_k[c] >= 0) begin
        b = bank_hist[e_a[c] - 1];
        chk($sformatf("v%0d c%0d coefficient_num", vi, c), coefficient_num, e_k[c]);
        chk($sformatf("v%0d c%0d fir_coefficient", vi, c), fir_coefficient, b[e_k[c] * 16 +: 16]);
      end
      if (clear_new_coeff) clears++;
      drive(c);
    end
    chk($sformatf("v%0d clear pulse count", vi), clears, v.exp_clears);
    chk($sformatf("v%0d final load_err", vi), load_err, v.exp_err);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    //        bank                    d    h    drop  rnd clr err
    vecs[0]  = '{64'h8000_8000_4000_4000, 2,   2,   3,    0,  1,  0};  // nominal
    vecs[1]  = '{64'h1111_2222_3333_4444, 2,   2,   8,    0,  1,  0};  // dropped after coeff 1
    vecs[2]  = '{64'h0A0A_0B0B_0C0C_0D0D, 1,   1,   MAXC, 0,  3,  0};  // request held
    vecs[3]  = '{64'h1234_5678_9ABC_DEF0, 200, 1,   3,    0,  0,  1};  // modwait stuck low
    vecs[4]  = '{64'h1234_5678_9ABC_DEF0, 1,   200, 3,    0,  0,  1};  // modwait stuck high
    vecs[5]  = '{64'hFFFF_0001_7FFF_8000, 9,   1,   3,    0,  1,  0};  // ack on last allowed cycle
    vecs[6]  = '{64'hFFFF_0001_7FFF_8000, 10,  1,   3,    0,  0,  1};  // ack one cycle late
    vecs[7]  = '{64'h5555_AAAA_5555_AAAA, 1,   10,  3,    0,  1,  0};  // release on last allowed cycle
    vecs[8]  = '{64'h5555_AAAA_5555_AAAA, 1,   11,  3,    0,  0,  1};  // release one cycle late
    vecs[9]  = '{64'h0000_0000_0000_0001, 200, 1,   MAXC, 0,  0,  1};  // timeout with request held
    for (int i = 10; i < NV; i++) begin
      vecs[i] = '{{$urandom, $urandom}, int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
                  int'($urandom_range(6, 1)), 1'b1, 1, 1'b0};
    end

    for (int vi = 0; vi < NV; vi++) run_vec(vi);

    // Reset asserted while coefficient 2 is being offered.
    cur_d = 2; cur_h = 2; cur_drop = MAXC; cur_rnd = 0;
    coeff_bank = 64'hAAAA_BBBB_CCCC_DDDD;
    apply_reset();
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (c > 0) begin
        @(posedge tb_clk);
        #1;
      end
      if (load_coeff && coefficient_num == 2'd2) found = 1;
      else drive(c);
    end
    chk("reach coefficient 2", found, 1'b1);
    n_reset = 1'b0;
    #2;
    chk("async reset load_coeff", load_coeff, 1'b0);
    chk("async reset busy", busy, 1'b0);
    chk("async reset clear_new_coeff", clear_new_coeff, 1'b0);
    chk("async reset load_err", load_err, 1'b0);
    chk("async reset coefficient_num", coefficient_num, 2'd0);
    chk("async reset fir_coefficient", fir_coefficient, 16'h0000);
    @(posedge tb_clk);
    #1;
    n_reset = 1'b1;
    new_coefficient_set = 1'b1;
    modwait = 1'b0;
    @(posedge tb_clk);
    #1;
    chk("restart load_coeff", load_coeff, 1'b1);
    chk("restart coefficient_num", coefficient_num, 2'd0);
    chk("restart fir_coefficient", fir_coefficient, 16'hDDDD);
    chk("restart busy", busy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coeff_loader.md
# coeff_loader

Sequencer directly upstream of `fir_filter`. On a new-coefficient-set request it walks the four coefficients of a 4×16-bit coefficient bank into the filter, one at a time, using the filter's `load_coeff`/`modwait` handshake. When all four are accepted it pulses a clear back to the request source. A per-coefficient timeout flags a filter that never acknowledges.

## Interface
- NUM_COEFF, 4, coefficients per set (fixed at 4; `coefficient_num` is 2 bits)
- TIMEOUT, 10, max cycles to wait for each `modwait` edge before flagging `load_err`
- clk  in  1  system clock, all state on rising edge
- n_reset  in  1  asynchronous, active-low reset
- new_coefficient_set  in  1  level request: a full coefficient set is ready in `coeff_bank`
- coeff_bank  in  64  coefficients, F0 = [15:0], F1 = [31:16], F2 = [47:32], F3 = [63:48]
- modwait  in  1  busy flag from `fir_filter`
- fir_coefficient  out  16  registered coefficient presented to `fir_filter`
- load_coeff  out  1  registered load request to `fir_filter`
- coefficient_num  out  2  index of the coefficient currently being loaded
- clear_new_coeff  out  1  one-cycle pulse: set fully loaded, request may be cleared
- busy  out  1  high in any state other than IDLE
- load_err  out  1  sticky: a handshake timed out

## Operation
- The FSM is Moore. All outputs are registered or decoded from registered state.
- States: IDLE, ASSERT, WAIT_LO, NEXT, DONE, ERR.
- IDLE
  - Outputs: `load_coeff`=0, `busy`=0.
  - If `new_coefficient_set`=1: idx←0, `fir_coefficient`←F0, go to ASSERT.
- ASSERT
  - Outputs: `load_coeff`=1.
  - `fir_coefficient` and `coefficient_num`=idx are held stable.
  - When `modwait` is sampled 1: go to WAIT_LO, `load_coeff`←0.
- WAIT_LO
  - Outputs: `load_coeff`=0.
  - When `modwait` is sampled 0: go to NEXT.
- NEXT
  - If idx=3: go to DONE.
  - Else: idx←idx+1, `fir_coefficient`←F[idx+1], go to ASSERT.
- DONE
  - `clear_new_coeff`=1 for exactly this one cycle, then go to IDLE.
- ERR
  - Entered when the timeout counter reaches TIMEOUT in ASSERT or WAIT_LO.
  - Outputs: `load_coeff`=0, `load_err`=1.
  - Go to IDLE on the next cycle. `load_err` stays 1 until reset.
  - `clear_new_coeff` is not pulsed.
- Timeout counter
  - Cleared on every state entry; increments each cycle spent in ASSERT or WAIT_LO.
  - Width is ceil(log2(TIMEOUT+1)).
- `coeff_bank` is sampled only at the idx update. Changes to the bank mid-sequence affect only coefficients not yet selected.
- Deassertion of `new_coefficient_set` mid-sequence is ignored; the sequence completes.
- Leaving IDLE needs `new_coefficient_set`=1 again. If the source has not cleared it by the cycle after DONE, a new sequence starts (no edge detect).
- `modwait` already 1 on entry to ASSERT counts as the acknowledge. The filter may still be finishing a sample; the loader does not distinguish.

## Timing
- Reset values:
  - state=IDLE, idx=0
  - `fir_coefficient`=16'h0000, `load_coeff`=0, `coefficient_num`=0
  - `clear_new_coeff`=0, `busy`=0, `load_err`=0
- Reset asserted mid-sequence: immediate return to IDLE with reset values. No clear pulse.
- Request to filter: `new_coefficient_set` is sampled high at edge N; `load_coeff`=1 and `fir_coefficient`=F0 are valid after edge N+1.
- `load_coeff` drops on the edge after `modwait` is sampled 1. Minimum `load_coeff` width is 1 cycle; it is held as long as the filter's synchronizer needs.
- Next coefficient: if `modwait` is sampled 0 at edge M, NEXT is entered at M+1 and ASSERT for coefficient k+1 at M+2.
- With an ideal filter (modwait 1 cycle after `load_coeff`, 1 cycle high), a set completes in ≤ 4×5+2 cycles.
- `busy` is high from the cycle after the request through the DONE or ERR cycle inclusive.

## Test plan
- Nominal load
  - Stimulus: reset; `coeff_bank`={8000,8000,4000,4000}; `new_coefficient_set`=1; model filter raises `modwait` 2 cycles after `load_coeff` and holds it 2 cycles.
  - Required: four ASSERT phases with `fir_coefficient`=4000, 4000, 8000, 8000 and `coefficient_num`=0..3; one `clear_new_coeff` pulse; `load_err`=0.
- Integration
  - Stimulus: connect to the real `fir_filter`; load {4000,8000,8000,4000}; drive four samples of 100.
  - Required: `fir_out` = 0, 50, 50, 50, `err`=0.
- Timeout
  - Stimulus: tie `modwait`=0.
  - Required: `load_coeff` high for exactly TIMEOUT cycles; then ERR, `load_err`=1 sticky; `busy` falls; no clear pulse.
- Stuck busy
  - Stimulus: `modwait` rises and then stays 1.
  - Required: timeout in WAIT_LO → `load_err`=1.
- Reset mid-operation
  - Stimulus: assert `n_reset`=0 during ASSERT of coefficient 2.
  - Required: all outputs at reset values asynchronously; after release, a fresh request starts again from `coefficient_num`=0.
- Request held
  - Stimulus: `new_coefficient_set` held 1 through DONE.
  - Required: a second sequence starts on the cycle after DONE.
- Request dropped
  - Stimulus: `new_coefficient_set` dropped after coefficient 1.
  - Required: the sequence still completes all four coefficients and pulses `clear_new_coeff`.
